// File: rtl/pipe_ctrl_unit_if.sv
// Purpose: bundles the ID-stage inputs and the per-stage control outputs of pipe_ctrl_unit.
// Latency: none; this is wiring only.
// Backpressure: none here; stalls are reported on id_stall by the control unit.
// Ports: id_valid/id_opcode/id_rs1/id_rs2/id_rd/ex_br_taken flow into the unit (slave side);
//        id_stall, if_flush, ex_*, mem_*, wb_*, fwd_a/fwd_b and illegal_cnt flow out of it.
interface pipe_ctrl_unit_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 8
);
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic [RA_W-1:0]  id_rd;
    logic             ex_br_taken;

    logic             id_stall;
    logic             if_flush;
    logic [1:0]       ex_aluop;
    logic             ex_alusrc;
    logic             ex_branch;
    logic             mem_read;
    logic             mem_write;
    logic             wb_regwrite;
    logic             wb_memtoreg;
    logic [RA_W-1:0]  wb_rd;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] illegal_cnt;

    // Pipeline front end / bench side
    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_br_taken,
        input  id_stall, if_flush, ex_aluop, ex_alusrc, ex_branch,
               mem_read, mem_write, wb_regwrite, wb_memtoreg, wb_rd,
               fwd_a, fwd_b, illegal_cnt
    );

    // Control unit side
    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_br_taken,
        output id_stall, if_flush, ex_aluop, ex_alusrc, ex_branch,
               mem_read, mem_write, wb_regwrite, wb_memtoreg, wb_rd,
               fwd_a, fwd_b, illegal_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Purpose: 5-stage pipeline control: decode, ID/EX->EX/MEM->MEM/WB control shift, hazard stall, flush, forwarding.
// Latency: EX controls 1 cycle after ID, MEM 2, WB 3; id_stall/if_flush/fwd_* are combinational.
// Backpressure: id_stall holds PC and IF/ID on hazards; ex_br_taken squashes IF/ID and overrides stall.
// Ports: clk, rst (sync, active high); bus = pipe_ctrl_unit_if.slave carrying ID inputs and stage outputs.
module pipe_ctrl_unit #(
    parameter int RA_W   = 5,
    parameter int CNT_W  = 8,
    parameter int FWD_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_unit_if.slave bus
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
    } ctrl_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
    } idex_t;

    // Later stages keep only the fields they still consume.
    typedef struct packed {
        logic            memread;
        logic            memwrite;
        logic            regwrite;
        logic            memtoreg;
        logic [RA_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic            regwrite;
        logic            memtoreg;
        logic [RA_W-1:0] rd;
    } memwb_t;

    idex_t            idex;
    exmem_t           exmem;
    memwb_t           memwb;
    logic [CNT_W-1:0] illegal_cnt_q;

    ctrl_t dec;
    logic  legal;
    logic  use_rs1;
    logic  use_rs2;
    logic  load_use;
    logic  raw;
    logic  stall_cond;
    logic  bubble;
    logic  cnt_inc;

    // True when a producer with a non-zero rd feeds a source the ID instruction actually reads.
    function automatic logic src_hit(
        input logic [RA_W-1:0] rd,
        input logic [RA_W-1:0] rs1,
        input logic [RA_W-1:0] rs2,
        input logic            u1,
        input logic            u2
    );
        return (rd != '0) && ((u1 && (rd == rs1)) || (u2 && (rd == rs2)));
    endfunction

    always_comb begin
        dec     = '0;
        legal   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (bus.id_opcode)
            OP_R: begin
                dec.aluop    = 2'b10;
                dec.regwrite = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_I: begin
                dec.aluop    = 2'b11;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_LD: begin
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
            end
            OP_ST: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_BR: begin
                dec.aluop    = 2'b01;
                dec.branch   = 1'b1;
                use_rs2      = 1'b1;
            end
            default: begin
                legal   = 1'b0;
                use_rs1 = 1'b0;
            end
        endcase
    end

    always_comb begin
        load_use = idex.ctrl.memread &&
                   src_hit(idex.rd, bus.id_rs1, bus.id_rs2, use_rs1, use_rs2);
        raw      = (idex.ctrl.regwrite &&
                    src_hit(idex.rd, bus.id_rs1, bus.id_rs2, use_rs1, use_rs2)) ||
                   (exmem.regwrite &&
                    src_hit(exmem.rd, bus.id_rs1, bus.id_rs2, use_rs1, use_rs2));
        // Without forwarding every RAW dependency on an in-flight producer must wait.
        stall_cond = load_use || ((FWD_EN == 0) && raw);
        bubble     = !bus.id_valid || stall_cond || bus.ex_br_taken;
        cnt_inc    = bus.id_valid && !stall_cond && !bus.ex_br_taken && !legal;
    end

    always_comb begin
        bus.fwd_a = 2'b00;
        bus.fwd_b = 2'b00;
        if (FWD_EN != 0) begin
            if (exmem.regwrite && (exmem.rd != '0) && (exmem.rd == idex.rs1))
                bus.fwd_a = 2'b10;
            else if (memwb.regwrite && (memwb.rd != '0) && (memwb.rd == idex.rs1))
                bus.fwd_a = 2'b01;
            if (exmem.regwrite && (exmem.rd != '0) && (exmem.rd == idex.rs2))
                bus.fwd_b = 2'b10;
            else if (memwb.regwrite && (memwb.rd != '0) && (memwb.rd == idex.rs2))
                bus.fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex          <= '0;
            exmem         <= '0;
            memwb         <= '0;
            illegal_cnt_q <= '0;
        end else begin
            // Bubbles clear the whole slot, source addresses included, so they never trigger forwarding.
            if (bubble) begin
                idex <= '0;
            end else begin
                idex.ctrl <= dec;
                idex.rd   <= bus.id_rd;
                idex.rs1  <= bus.id_rs1;
                idex.rs2  <= bus.id_rs2;
            end
            exmem.memread  <= idex.ctrl.memread;
            exmem.memwrite <= idex.ctrl.memwrite;
            exmem.regwrite <= idex.ctrl.regwrite;
            exmem.memtoreg <= idex.ctrl.memtoreg;
            exmem.rd       <= idex.rd;
            memwb.regwrite <= exmem.regwrite;
            memwb.memtoreg <= exmem.memtoreg;
            memwb.rd       <= exmem.rd;
            if (cnt_inc && (illegal_cnt_q != '1))
                illegal_cnt_q <= illegal_cnt_q + 1'b1;
        end
    end

    // Flush wins over stall: a squashed slot has nothing worth holding.
    assign bus.id_stall    = stall_cond && !bus.ex_br_taken;
    assign bus.if_flush    = bus.ex_br_taken;
    assign bus.ex_aluop    = idex.ctrl.aluop;
    assign bus.ex_alusrc   = idex.ctrl.alusrc;
    assign bus.ex_branch   = idex.ctrl.branch;
    assign bus.mem_read    = exmem.memread;
    assign bus.mem_write   = exmem.memwrite;
    assign bus.wb_regwrite = memwb.regwrite;
    assign bus.wb_memtoreg = memwb.memtoreg;
    assign bus.wb_rd       = memwb.rd;
    assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Purpose: directed bench for pipe_ctrl_unit with a forwarding instance (u0) and a stall-only instance (u1).
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: stalls are exercised directly by holding the ID inputs while id_stall is high.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [4:0] rd;
        logic       m2r;
    } wb_exp_t;

    wb_exp_t sb[$];

    pipe_ctrl_unit_if #(.RA_W(5), .CNT_W(8)) b0 ();
    pipe_ctrl_unit_if #(.RA_W(5), .CNT_W(8)) b1 ();

    pipe_ctrl_unit #(.RA_W(5), .CNT_W(8), .FWD_EN(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    pipe_ctrl_unit #(.RA_W(5), .CNT_W(8), .FWD_EN(0)) u1 (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // which: 0 -> u0 only, 1 -> u1 only, 2 -> both; the other instance sees an idle slot.
    task automatic drive(input int which, input logic v, input logic [6:0] op,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic br);
        b0.id_valid = 1'b0; b0.id_opcode = '0; b0.id_rs1 = '0; b0.id_rs2 = '0;
        b0.id_rd = '0; b0.ex_br_taken = 1'b0;
        b1.id_valid = 1'b0; b1.id_opcode = '0; b1.id_rs1 = '0; b1.id_rs2 = '0;
        b1.id_rd = '0; b1.ex_br_taken = 1'b0;
        if (which != 1) begin
            b0.id_valid = v; b0.id_opcode = op; b0.id_rs1 = rs1; b0.id_rs2 = rs2;
            b0.id_rd = rd; b0.ex_br_taken = br;
        end
        if (which != 0) begin
            b1.id_valid = v; b1.id_opcode = op; b1.id_rs1 = rs1; b1.id_rs2 = rs2;
            b1.id_rd = rd; b1.ex_br_taken = br;
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) begin
            drive(2, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
            next();
        end
    endtask

    // Scoreboard consumer: every register write leaving u0's WB stage must match the oldest expectation.
    always @(negedge clk) begin
        wb_exp_t e;
        if (b0.wb_regwrite === 1'b1) begin
            chk("sb_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_wb_rd", 32'(b0.wb_rd), 32'(e.rd));
                chk("sb_wb_memtoreg", 32'(b0.wb_memtoreg), 32'(e.m2r));
            end
        end
    end

    initial begin
        int exp_cnt;
        rst = 1'b1;
        drive(2, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        next();
        next();
        @(negedge clk);
        chk("rst_outputs", {b0.ex_aluop, b0.ex_alusrc, b0.ex_branch, b0.mem_read, b0.mem_write,
                            b0.wb_regwrite, b0.wb_memtoreg, b0.wb_rd, b0.fwd_a, b0.fwd_b}, 0);
        chk("rst_stall_flush", {b0.id_stall, b0.if_flush, b1.id_stall, b1.if_flush}, 0);
        chk("rst_cnt", b0.illegal_cnt, 0);
        next();
        rst = 1'b0;

        // add x3,x1,x2: EX one cycle later, WB three cycles after issue
        drive(0, 1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
        sb.push_back('{rd: 5'd3, m2r: 1'b0});
        @(negedge clk); chk("A_stall", b0.id_stall, 0); next();
        drive(0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("A_ex_aluop", b0.ex_aluop, 2'b10); chk("A_ex_alusrc", b0.ex_alusrc, 0); next();
        @(negedge clk); chk("A_mem_read", b0.mem_read, 0); chk("A_wb_early", b0.wb_regwrite, 0); next();
        @(negedge clk); chk("A_wb_regwrite", b0.wb_regwrite, 1); chk("A_wb_rd", b0.wb_rd, 3); next();

        // I-ALU then branch decode
        drive(0, 1'b1, OP_I, 5'd1, 5'd0, 5'd12, 1'b0);
        sb.push_back('{rd: 5'd12, m2r: 1'b0});
        @(negedge clk); next();
        drive(0, 1'b1, OP_BR, 5'd1, 5'd2, 5'd0, 1'b0);
        @(negedge clk); chk("G_aluop_i", b0.ex_aluop, 2'b11); chk("G_alusrc_i", b0.ex_alusrc, 1); next();
        drive(0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("G_aluop_br", b0.ex_aluop, 2'b01); chk("G_branch", b0.ex_branch, 1); next();
        idle_n(4);

        // lw x5 then R-type using x5: one stall, one bubble, then MEM/WB forward
        drive(0, 1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);
        sb.push_back('{rd: 5'd5, m2r: 1'b1});
        @(negedge clk); chk("B_ld_stall", b0.id_stall, 0); next();
        drive(0, 1'b1, OP_R, 5'd5, 5'd7, 5'd6, 1'b0);
        @(negedge clk); chk("B_stall", b0.id_stall, 1); chk("B_ex_load_alusrc", b0.ex_alusrc, 1); next();
        @(negedge clk);
        chk("B_stall_released", b0.id_stall, 0);
        chk("B_bubble", {b0.ex_aluop, b0.ex_alusrc, b0.ex_branch}, 0);
        sb.push_back('{rd: 5'd6, m2r: 1'b0});
        next();
        drive(0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("B_fwd_a", b0.fwd_a, 2'b01); chk("B_fwd_b", b0.fwd_b, 0);
        chk("B_ex_aluop", b0.ex_aluop, 2'b10); chk("B_mem_bubble", b0.mem_read, 0);
        next();
        idle_n(4);

        // add x4 then sub using x4 as rs2, forwarding instance
        drive(0, 1'b1, OP_R, 5'd1, 5'd2, 5'd4, 1'b0);
        sb.push_back('{rd: 5'd4, m2r: 1'b0});
        @(negedge clk); next();
        drive(0, 1'b1, OP_R, 5'd3, 5'd4, 5'd8, 1'b0);
        @(negedge clk); chk("C_fwd_nostall", b0.id_stall, 0);
        sb.push_back('{rd: 5'd8, m2r: 1'b0});
        next();
        drive(0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("C_fwd_b", b0.fwd_b, 2'b10); chk("C_fwd_a", b0.fwd_a, 0); next();
        idle_n(4);

        // same pair, stall-only instance: two stall cycles, no forwarding
        drive(1, 1'b1, OP_R, 5'd1, 5'd2, 5'd4, 1'b0);
        @(negedge clk); next();
        drive(1, 1'b1, OP_R, 5'd3, 5'd4, 5'd8, 1'b0);
        @(negedge clk); chk("C_nofwd_stall1", b1.id_stall, 1); next();
        @(negedge clk); chk("C_nofwd_stall2", b1.id_stall, 1); next();
        @(negedge clk);
        chk("C_nofwd_stall3", b1.id_stall, 0);
        chk("C_nofwd_wb_regwrite", b1.wb_regwrite, 1); chk("C_nofwd_wb_rd", b1.wb_rd, 4);
        next();
        drive(1, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("C_nofwd_fwd_b", b1.fwd_b, 0); chk("C_nofwd_ex_aluop", b1.ex_aluop, 2'b10); next();
        idle_n(4);

        // branch taken coinciding with a load-use hazard
        drive(0, 1'b1, OP_LD, 5'd1, 5'd0, 5'd9, 1'b0);
        sb.push_back('{rd: 5'd9, m2r: 1'b1});
        @(negedge clk); next();
        drive(0, 1'b1, OP_R, 5'd9, 5'd2, 5'd10, 1'b1);
        @(negedge clk); chk("D_flush", b0.if_flush, 1); chk("D_stall", b0.id_stall, 0); next();
        drive(0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("D_idex_zero", {b0.ex_aluop, b0.ex_alusrc, b0.ex_branch}, 0);
        chk("D_fwd_a", b0.fwd_a, 0); chk("D_mem_read", b0.mem_read, 1);
        next();
        idle_n(4);

        // 260 illegal opcodes: counter saturates at 255, no controls
        exp_cnt = 0;
        for (int k = 0; k < 260; k++) begin
            drive(2, 1'b1, OP_BAD, 5'(k), 5'(k + 1), 5'(k + 2), 1'b0);
            @(negedge clk);
            chk("F_cnt_fwd", b0.illegal_cnt, exp_cnt);
            chk("F_cnt_nofwd", b1.illegal_cnt, exp_cnt);
            chk("F_ctrl_zero", {b0.ex_aluop, b0.ex_alusrc, b0.ex_branch, b0.mem_read, b0.mem_write,
                                b0.wb_regwrite, b0.wb_memtoreg, b0.id_stall, b0.if_flush,
                                b0.fwd_a, b0.fwd_b}, 0);
            next();
            if (exp_cnt < 255) exp_cnt++;
        end
        drive(2, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("F_cnt_hold", b0.illegal_cnt, 255); chk("F_cnt_hold1", b1.illegal_cnt, 255); next();

        // reset with store in MEM and load in EX
        drive(0, 1'b1, OP_ST, 5'd1, 5'd2, 5'd0, 1'b0);
        @(negedge clk); next();
        drive(0, 1'b1, OP_LD, 5'd1, 5'd0, 5'd11, 1'b0);
        @(negedge clk); next();
        drive(0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("E_mem_write_pre", b0.mem_write, 1); chk("E_ex_alusrc_pre", b0.ex_alusrc, 1);
        rst = 1'b1;
        next();
        @(negedge clk);
        chk("E_rst_mem", {b0.mem_read, b0.mem_write}, 0);
        chk("E_rst_ex", {b0.ex_aluop, b0.ex_alusrc}, 0);
        chk("E_rst_cnt", b0.illegal_cnt, 0);
        next();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("E_post_rst_mem", {b0.mem_read, b0.mem_write, b0.wb_regwrite}, 0);
            next();
        end

        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 8, meaning illegal-opcode counter width.
REQ-003 SHALL have parameter FWD_EN, default 1, meaning 1 = forwarding mode, 0 = stall-only mode.
REQ-004 SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-005 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port id_valid, input, 1, meaning the ID-stage instruction is valid.
REQ-007 SHALL have port id_opcode, input, 7, meaning the ID-stage opcode.
REQ-008 SHALL have ports id_rs1, id_rs2 and id_rd, input, RA_W each, meaning the ID-stage register addresses.
REQ-009 SHALL have port ex_br_taken, input, 1, meaning a branch resolved taken in EX this cycle.
REQ-010 SHALL have port id_stall, output, 1, meaning hold PC and IF/ID.
REQ-011 SHALL have port if_flush, output, 1, meaning squash IF/ID.
REQ-012 SHALL have ports ex_aluop (output, 2), ex_alusrc (output, 1) and ex_branch (output, 1), meaning EX-stage controls.
REQ-013 SHALL have ports mem_read and mem_write, output, 1 each, meaning MEM-stage controls.
REQ-014 SHALL have ports wb_regwrite and wb_memtoreg (output, 1 each) and wb_rd (output, RA_W), meaning WB-stage controls.
REQ-015 SHALL have ports fwd_a and fwd_b, output, 2 each, meaning operand-forwarding selects for EX.
REQ-016 SHALL have port illegal_cnt, output, CNT_W, meaning the count of illegal opcodes decoded.

Function
REQ-017 SHALL decode the bundle {aluop, alusrc, branch, memread, memwrite, regwrite, memtoreg} per opcode as follows.
- 0110011 (R-type): {10,0,0,0,0,1,0}
- 0010011 (I-ALU): {11,1,0,0,0,1,0}
- 0000011 (load): {00,1,0,1,0,1,1}
- 0100011 (store): {00,1,0,0,1,0,0}
- 1100011 (branch): {01,0,1,0,0,0,0}
- any other opcode: all-zero bundle (bubble)
REQ-018 SHALL treat rs2 as used for R-type, store and branch, and rs1 as used for all five legal opcodes.
REQ-019 SHALL register the decoded bundle plus rd, rs1 and rs2 into ID/EX each cycle.
- Inserted values are the all-zero bundle when id_valid=0, id_stall=1 or ex_br_taken=1.
REQ-020 SHALL shift ID/EX into EX/MEM and EX/MEM into MEM/WB every cycle, unconditionally, with 1-cycle latency per stage.
REQ-021 SHALL drive the EX, MEM and WB outputs directly from the ID/EX, EX/MEM and MEM/WB registers respectively.
REQ-022 SHALL assert id_stall combinationally on a load-use hazard.
- Condition: ID/EX memread=1, ID/EX rd!=0, and ID/EX rd equals a used ID source register.
REQ-023 SHALL, when FWD_EN=0, also assert id_stall on a RAW hazard.
- Condition: ID/EX or EX/MEM has regwrite=1, a non-zero rd, and that rd equals a used ID source register.
REQ-024 SHALL, when FWD_EN=1, drive fwd_a as follows.
- 10 if EX/MEM regwrite=1, EX/MEM rd!=0 and EX/MEM rd == ID/EX rs1.
- Else 01 if the same condition holds for MEM/WB.
- Else 00.
- EX/MEM has priority over MEM/WB.
REQ-025 SHALL derive fwd_b identically to fwd_a using ID/EX rs2.
REQ-026 SHALL hold fwd_a and fwd_b at 00 when FWD_EN=0.
REQ-027 SHALL drive if_flush equal to ex_br_taken, combinationally.
REQ-028 SHALL give flush priority over stall.
- When ex_br_taken=1 and a hazard coincide: id_stall=0, if_flush=1, and a bubble enters ID/EX.
REQ-029 SHALL increment illegal_cnt by 1 on each cycle with id_valid=1, id_stall=0, ex_br_taken=0 and an undefined opcode.
REQ-030 SHALL saturate illegal_cnt at 2^CNT_W-1, with no wrap-around.
REQ-031 SHALL never assert register-write or memory controls for an instruction that was bubbled or flushed.

Reset
REQ-032 SHALL, when rst=1 at a rising edge, clear ID/EX, EX/MEM, MEM/WB and illegal_cnt to all-zero on that edge.
REQ-033 SHALL hold all outputs at 0 during reset.
- Exception: id_stall and if_flush follow their combinational inputs.
- These evaluate to 0 once the pipeline is cleared, with ex_br_taken=0.
REQ-034 SHALL abandon in-flight instructions on reset asserted mid-operation.
- No write controls appear after reset deasserts until new valid instructions propagate.

Verification
REQ-035 SHALL cover R-type "add x3,x1,x2" with id_valid=1 -> ex_aluop=10 one cycle later, and wb_regwrite=1 with wb_rd=3 three cycles after issue.
REQ-036 SHALL cover "lw x5" followed by R-type with rs1=5 -> id_stall=1 for exactly 1 cycle, one bubble in ID/EX, then fwd_a=01 when the R-type reaches EX.
REQ-037 SHALL cover "add x4" followed by "sub" with rs2=4, with FWD_EN=1 -> no stall and fwd_b=10; with FWD_EN=0 -> id_stall=1 for 2 cycles and fwd_b=00.
REQ-038 SHALL cover ex_br_taken=1 in the same cycle as a load-use hazard -> if_flush=1, id_stall=0, ID/EX all-zero next cycle.
REQ-039 SHALL cover 260 consecutive valid opcodes 1111111 with CNT_W=8 -> illegal_cnt reaches 255 and holds; all control outputs remain 0.
REQ-040 SHALL cover rst asserted while store and load are in EX and MEM -> mem_read=0 and mem_write=0 from the reset edge onward.
